// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches to
// instruction memory, buffers returned words in a small FIFO and hands them
// to decode over a valid/ready handshake. A PC redirect from control (taken
// together with a decode handshake) flushes the buffer and drops the
// responses of every wrong-path fetch still in flight.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   PCSel, pc_target             redirect request / target (low two bits ignored)
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_gnt                     request accepted this cycle
//   imem_rvalid, imem_rdata      in-order response
//   instr_valid, instr_ready     handshake with decode
//   instruction, instr_pc        buffer head word and its PC
//   pc_plus4                     instr_pc + 4 (link value)
module fetch_unit #(
  parameter int unsigned            instructionwidth = 32,
  parameter int unsigned            ADDRWIDTH        = 32,
  parameter logic [ADDRWIDTH-1:0]   RESET_PC         = '0,
  parameter int unsigned            DEPTH            = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PCSel,
  input  logic [ADDRWIDTH-1:0]        pc_target,
  output logic                        imem_req,
  output logic [ADDRWIDTH-1:0]        imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [instructionwidth-1:0] imem_rdata,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [instructionwidth-1:0] instruction,
  output logic [ADDRWIDTH-1:0]        instr_pc,
  output logic [ADDRWIDTH-1:0]        pc_plus4
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for occupancy + outstanding + 1 without overflow.
  localparam int unsigned CW = $clog2(2 * DEPTH + 2) + 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                      state;
  state_t                      state_n;
  logic [ADDRWIDTH-1:0]        fetch_pc;
  logic [ADDRWIDTH-1:0]        ret_pc;
  logic [CW-1:0]               occ;
  logic [CW-1:0]               outstanding;
  logic [CW-1:0]               out_next;
  logic [CW-1:0]               drop;
  logic [PW-1:0]               rd_ptr;
  logic [PW-1:0]               wr_ptr;
  logic [instructionwidth-1:0] buf_data [DEPTH];
  logic [ADDRWIDTH-1:0]        buf_pc   [DEPTH];

  logic pop;
  logic redirect;
  logic grant;
  logic resp;
  logic push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Handshake and memory-side event decode.
  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && PCSel;
  assign grant    = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp     = imem_rvalid && (outstanding != '0);
  assign out_next = outstanding + CW'(grant) - CW'(resp);
  // A response arriving on the redirect edge belongs to the wrong path.
  assign push     = resp && (state == RUN) && !redirect;

  // Outputs. Pop credit lets a new request go out while the head leaves,
  // which is what sustains one instruction per cycle with DEPTH=2.
  assign instr_valid = !rst && (state == RUN) && (occ != '0);
  assign imem_req    = !rst && (state == RUN) &&
                       ((occ + outstanding) < (CW'(DEPTH) + CW'(pop)));
  assign imem_addr   = fetch_pc;
  assign instruction = instr_valid ? buf_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;
  assign pc_plus4    = instr_valid ? buf_pc[rd_ptr] + ADDRWIDTH'(4) : '0;

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (redirect && (out_next != '0)) state_n = FLUSH;
      FLUSH:   if (resp && (drop == CW'(1)))     state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // State, PC, counters and FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_n;
      outstanding <= out_next;

      if (redirect)   fetch_pc <= pc_target & ~ADDRWIDTH'(3);
      else if (grant) fetch_pc <= fetch_pc + ADDRWIDTH'(4);

      if (redirect) begin
        ret_pc <= pc_target & ~ADDRWIDTH'(3);
        occ    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        drop   <= out_next;
      end else begin
        if (push) begin
          buf_data[wr_ptr] <= imem_rdata;
          buf_pc[wr_ptr]   <= ret_pc;
          wr_ptr           <= ptr_inc(wr_ptr);
          ret_pc           <= ret_pc + ADDRWIDTH'(4);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        occ <= occ + CW'(push) - CW'(pop);
        if (resp && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Memory must never return more responses than were granted.
  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSel;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;

  // Second instance with a wrapping reset PC.
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] b_pc;
  logic [31:0] b_plus4;
  logic [31:0] b_ra;

  int          checks = 0;
  int          errors = 0;
  int          gcount = 0;
  int          glimit = 0;
  logic        gnt_en = 1'b0;
  logic        redir_en = 1'b0;
  logic        pcsel_force = 1'b0;
  logic [31:0] ra;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  always #5 clk = ~clk;

  assign imem_gnt  = gnt_en && (gcount < glimit);
  assign PCSel     = pcsel_force || (redir_en && instr_valid && (instr_pc == 32'h8));
  assign pc_target = 32'h103;

  fetch_unit dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .PCSel(1'b0), .pc_target(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(1'b1),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .instr_valid(b_valid), .instr_ready(1'b1),
    .instruction(b_instr), .instr_pc(b_pc), .pc_plus4(b_plus4)
  );

  // One-cycle memories: word at address a holds 0x13 + a.
  always @(posedge clk) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      b_rvalid    <= 1'b0;
    end else begin
      imem_rvalid <= imem_req && imem_gnt;
      b_rvalid    <= b_req;
    end
    ra   <= imem_addr;
    b_ra <= b_addr;
    if (imem_req && imem_gnt) gcount <= gcount + 1;
  end
  assign imem_rdata = 32'h13 + ra;
  assign b_rdata    = 32'h13 + b_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: grants and handshakes are checked against queues.
  always @(negedge clk) begin : mon
    logic [31:0] ep;
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        if (exp_addr.size() == 0) chk("grant_unexpected", imem_addr, 32'hDEAD_BEEF);
        else                      chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (exp_pc.size() == 0) begin
          chk("instr_unexpected", instr_pc, 32'hDEAD_BEEF);
        end else begin
          ep = exp_pc.pop_front();
          chk("instruction", instruction, 32'h13 + ep);
          chk("instr_pc", instr_pc, ep);
          chk("pc_plus4", pc_plus4, ep + 32'd4);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    tick();
    tick();
  endtask

  task automatic expect_addrs(input logic [31:0] a[$]);
    foreach (a[i]) exp_addr.push_back(a[i]);
    glimit = gcount + a.size();
  endtask

  task automatic expect_instrs(input logic [31:0] p[$]);
    foreach (p[i]) exp_pc.push_back(p[i]);
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (exp_addr.size() != 0 || exp_pc.size() != 0); i++) tick();
    chk("drain_left", 32'(exp_addr.size() + exp_pc.size()), 32'd0);
  endtask

  initial begin
    int g0;
    instr_ready = 1'b1;

    // Streaming with 1-cycle memory, plus first-cycle and wrapping-PC checks.
    do_reset();
    gnt_en = 1'b1;
    expect_addrs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C});
    expect_instrs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C});
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'd0);
    chk("b_first_addr", b_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("b_second_addr", b_addr, 32'h0);
    @(negedge clk);
    chk("b_head_valid", {31'b0, b_valid}, 32'd1);
    chk("b_head_pc", b_pc, 32'hFFFF_FFFC);
    chk("b_head_plus4", b_plus4, 32'h0);
    chk("b_head_instr", b_instr, 32'h0000_000F);
    drain();

    // Decode stalled: buffer fills, requests stop, head held; stray PCSel ignored.
    instr_ready = 1'b0;
    do_reset();
    expect_addrs('{32'h0, 32'h4, 32'h8, 32'hC});
    expect_instrs('{32'h0, 32'h4, 32'h8, 32'hC});
    pcsel_force = 1'b1;
    rst = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_req", {31'b0, imem_req}, 32'd0);
      chk("held_valid", {31'b0, instr_valid}, 32'd1);
      chk("held_instruction", instruction, 32'h13);
      chk("held_pc", instr_pc, 32'h0);
      tick();
    end
    pcsel_force = 1'b0;
    instr_ready = 1'b1;
    drain();

    // Redirect at head pc 0x8 to 0x103: wrong-path responses dropped.
    do_reset();
    redir_en = 1'b1;
    expect_addrs('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h108, 32'h10C});
    expect_instrs('{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108, 32'h10C});
    rst = 1'b0;
    drain();
    redir_en = 1'b0;

    // Grant withheld: request and address held, then a single fetch.
    do_reset();
    gnt_en = 1'b0;
    expect_addrs('{32'h0});
    expect_instrs('{32'h0});
    g0 = gcount;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0);
      tick();
    end
    gnt_en = 1'b1;
    drain();
    repeat (2) tick();
    @(negedge clk);
    chk("single_grant", 32'(gcount - g0), 32'd1);
    chk("next_req", {31'b0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
